i2s_tdm_master: RTL
===================

Name: i2s_tdm_master

Overview:
Parametrised successor to the team's fixed stereo I2S master. Generates frame sync (LRCLK/FS) from the incoming bit clock, serialises NCH channel words onto SDOUT and deserialises NCH words from SDIN. Supports I2S, left-justified and DSP/TDM framing, with slot width independent of data width and a frame-level handshake toward the audio datapath. Sits between the codec/ADC pins and the sample FIFOs, entirely in the i2s_bclk domain.

Parameters:
DSZ, 16, data bits per channel (1..SLOT_SZ)
SLOT_SZ, 32, BCLKs per slot (>= DSZ, >= 2)
NCH, 2, channels (slots) per frame; must be even for MODE 0/1; 2..16
MODE, 0, 0 = I2S (1-bit delay), 1 = left-justified (no delay), 2 = DSP/TDM (1-bit delay, 1-BCLK FS pulse)

Ports:
i2s_bclk  in  1  bit clock, the only clock; both edges used
reset  in  1  asynchronous, active-high reset
i2s_lrclk  out  1  word select (MODE 0/1) or frame sync pulse (MODE 2)
i2s_sdout  out  1  serial data out, changes on falling edge
i2s_sdin  in  1  serial data in, sampled on rising edge
tx_data  in  NCH*DSZ  channel words, channel 0 in bits [DSZ-1:0]
tx_valid  in  1  tx_data valid at capture point
tx_ready  out  1  one-BCLK pulse: tx_data captured this cycle
tx_underrun  out  1  one-BCLK pulse: capture occurred with tx_valid low
rx_data  out  NCH*DSZ  last complete received frame, same packing
rx_valid  out  1  one-BCLK pulse: rx_data updated

Behaviour:
- One clock: i2s_bclk; reset is asynchronous and active-high (port name reset). Reset clears all state immediately, no clock edge needed.
- FRAME = NCH*SLOT_SZ. Frame counter k (0..FRAME-1) advances on falling edge, wraps FRAME-1 -> 0. Reset value k = FRAME-1.
- DELAY = 1 for MODE 0/2, 0 for MODE 1. Bit position p = (k - DELAY) mod FRAME; slot s = p / SLOT_SZ; bit b = p mod SLOT_SZ.
- i2s_lrclk (registered, falling edge): MODE 0: 1 when k >= FRAME/2 else 0. MODE 1: 1 when k < FRAME/2. MODE 2: 1 only when k = 0.
- i2s_sdout in cycle k: word[s] bit (DSZ-1-b) if b < DSZ, else 0 (MSB first, zero padding).
- TX capture: on the falling edge entering p = 0 (k = DELAY). If tx_valid = 1, latch tx_data into shadow; else latch all zeros and pulse tx_underrun. tx_ready pulses in the same cycle either way. SDOUT in that cycle is already the MSB of the newly latched slot 0. Shadow is held stable for the whole frame; tx_data changes at other times have no effect.
- RX: on each rising edge, if b < DSZ, shift i2s_sdin into the word for slot s; bits b >= DSZ are ignored. On the rising edge with p = FRAME-1, copy all NCH words, including the bit sampled on that edge, into rx_data and pulse rx_valid high for one rising-to-rising period.
- rx_valid is suppressed until a full frame has been sampled from p = 0 after reset (primed flag), so no partial frame ever appears.
- Reset values: i2s_lrclk = value for k = FRAME-1 (MODE 0: 1, MODE 1: 0, MODE 2: 0); i2s_sdout 0; tx_ready, tx_underrun, rx_valid 0; rx_data 0; shadow and shift registers 0.
- Reset mid-frame: outputs go to reset values asynchronously. After release, the first falling edge gives k = 0 and framing restarts cleanly.
- SLOT_SZ = DSZ: no padding. The last bit of the frame comes from the previous shadow and must not be corrupted by the capture edge.

Decomposition:
- Package i2s_pkg: MODE_I2S/MODE_LJ/MODE_DSP constants; clog2 function; parameter-legality checks (elaboration error on SLOT_SZ < DSZ, odd NCH in MODE 0/1).
- Sub-module i2s_frame_timer: holds k, derives p/s/b and i2s_lrclk, and issues the capture and frame-end strobes. Shared with a future slave variant.

Test Plan:
- MODE 0, DSZ=16, SLOT_SZ=16, NCH=2, SDOUT looped to SDIN, tx = {0x0F0F, 0xA55A} -> LRCLK period 32 BCLK; second rx_valid shows rx_data = {0x0F0F, 0xA55A}; MSB of ch0 at k=1.
- MODE 2, DSZ=24, SLOT_SZ=32, NCH=8, loopback, ch3 = 0xC00001 -> FS high only at k=0, every 256 BCLK; ch3 MSB at k=97; k=121..128 SDOUT 0; ch3 received correctly.
- MODE 1, DSZ=16, SLOT_SZ=32, NCH=2 -> LRCLK high for k=0..31; left MSB at k=0; right MSB at k=32.
- tx_valid = 0 at capture -> all-zero frame on SDOUT; tx_underrun and tx_ready each pulse for exactly one cycle; next frame with tx_valid = 1 transmits normally.
- Reset asserted between edges at k=10 -> LRCLK/SDOUT at reset values without a clock edge; no rx_valid until one full post-reset frame; first post-reset rx_data is correct.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and elaboration helpers for the I2S/TDM master and its frame timer.
package i2s_pkg;

  localparam int unsigned MODE_I2S = 0;
  localparam int unsigned MODE_LJ  = 1;
  localparam int unsigned MODE_DSP = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that is never zero, even for a range of 1 or 2.
  function automatic int unsigned width_of(input int unsigned v);
    return (v <= 2) ? 1 : clog2(v);
  endfunction

  function automatic int unsigned frame_delay(input int unsigned mode);
    return (mode == MODE_LJ) ? 0 : 1;
  endfunction

  function automatic logic params_ok(input int unsigned dsz, input int unsigned slot_sz,
                                     input int unsigned nch, input int unsigned mode);
    return (dsz >= 1) && (slot_sz >= dsz) && (slot_sz >= 2) &&
           (nch >= 2) && (nch <= 16) && (mode <= MODE_DSP) &&
           ((mode == MODE_DSP) || (nch % 2 == 0));
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Frame position counter on the falling BCLK edge: k, delayed slot/bit position and LRCLK/FS.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter  int unsigned SLOT_SZ = 32,
  parameter  int unsigned NCH     = 2,
  parameter  int unsigned MODE    = MODE_I2S,
  localparam int unsigned SW      = width_of(NCH),
  localparam int unsigned BW      = width_of(SLOT_SZ)
)(
  input  logic          i2s_bclk,
  input  logic          reset,
  output logic          i2s_lrclk,
  output logic [SW-1:0] cur_slot,
  output logic [BW-1:0] cur_bit,
  output logic [SW-1:0] nxt_slot,
  output logic [BW-1:0] nxt_bit,
  output logic          frame_start,
  output logic          frame_end
);

  localparam int unsigned FRAME = NCH * SLOT_SZ;
  localparam int unsigned KW    = width_of(FRAME);
  localparam int unsigned P_RST = FRAME - 1 - frame_delay(MODE);

  localparam logic [KW-1:0] K_LAST = KW'(FRAME - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NCH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SLOT_SZ - 1);
  localparam logic [SW-1:0] S_RST  = SW'(P_RST / SLOT_SZ);
  localparam logic [BW-1:0] B_RST  = BW'(P_RST % SLOT_SZ);

  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;

  function automatic logic lr_at(input logic [KW-1:0] kk);
    case (MODE)
      MODE_I2S: return 32'(kk) >= FRAME / 2;
      MODE_LJ:  return 32'(kk) <  FRAME / 2;
      MODE_DSP: return kk == '0;
      default:  return 1'b0;
    endcase
  endfunction

  // p = (k - DELAY) mod FRAME is kept as a slot/bit counter pair that steps
  // in lockstep with k, so no divider is needed to split it.
  always_comb begin
    k_nxt       = (k == K_LAST) ? '0 : k + KW'(1);
    nxt_bit     = (cur_bit == B_LAST) ? '0 : cur_bit + BW'(1);
    nxt_slot    = cur_slot;
    if (cur_bit == B_LAST)
      nxt_slot  = (cur_slot == S_LAST) ? '0 : cur_slot + SW'(1);
    frame_start = (cur_slot == '0) && (cur_bit == '0);
    frame_end   = (cur_slot == S_LAST) && (cur_bit == B_LAST);
  end

  always_ff @(negedge i2s_bclk or posedge reset) begin
    if (reset) begin
      k         <= K_LAST;
      cur_slot  <= S_RST;
      cur_bit   <= B_RST;
      i2s_lrclk <= lr_at(K_LAST);
    end else begin
      k         <= k_nxt;
      cur_slot  <= nxt_slot;
      cur_bit   <= nxt_bit;
      i2s_lrclk <= lr_at(k_nxt);
    end
  end

endmodule

// File: rtl/i2s_tdm_master.sv
// I2S / left-justified / DSP-TDM bus master: frame-level TX capture and RX frame delivery.
module i2s_tdm_master
  import i2s_pkg::*;
#(
  parameter int unsigned DSZ     = 16,
  parameter int unsigned SLOT_SZ = 32,
  parameter int unsigned NCH     = 2,
  parameter int unsigned MODE    = MODE_I2S
)(
  input  logic               i2s_bclk,
  input  logic               reset,
  output logic               i2s_lrclk,
  output logic               i2s_sdout,
  input  logic               i2s_sdin,
  input  logic [NCH*DSZ-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_underrun,
  output logic [NCH*DSZ-1:0] rx_data,
  output logic               rx_valid
);

  localparam int unsigned SW = width_of(NCH);
  localparam int unsigned BW = width_of(SLOT_SZ);

  if (!params_ok(DSZ, SLOT_SZ, NCH, MODE)) begin : g_bad_params
    $error("i2s_tdm_master: illegal DSZ/SLOT_SZ/NCH/MODE combination");
  end

  logic [SW-1:0] cur_slot, nxt_slot;
  logic [BW-1:0] cur_bit, nxt_bit;
  logic          frame_start, frame_end;

  i2s_frame_timer #(
    .SLOT_SZ (SLOT_SZ),
    .NCH     (NCH),
    .MODE    (MODE)
  ) u_timer (
    .i2s_bclk    (i2s_bclk),
    .reset       (reset),
    .i2s_lrclk   (i2s_lrclk),
    .cur_slot    (cur_slot),
    .cur_bit     (cur_bit),
    .nxt_slot    (nxt_slot),
    .nxt_bit     (nxt_bit),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  logic [NCH-1:0][DSZ-1:0] shadow, tx_in, tx_word_src;
  logic                    sd_nxt;

  assign tx_in = tx_valid ? tx_data : '0;

  // The falling edge that leaves the last frame position is the capture edge;
  // the bit driven on that edge must already come from the new word.
  always_comb begin
    tx_word_src = frame_end ? tx_in : shadow;
    sd_nxt      = 1'b0;
    for (int unsigned i = 0; i < NCH; i++)
      for (int unsigned j = 0; j < DSZ; j++)
        if (32'(nxt_slot) == i && 32'(nxt_bit) == DSZ - 1 - j)
          sd_nxt = tx_word_src[i][j];
  end

  always_ff @(negedge i2s_bclk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      i2s_sdout   <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      i2s_sdout   <= sd_nxt;
      tx_ready    <= frame_end;
      tx_underrun <= frame_end & ~tx_valid;
      if (frame_end)
        shadow <= tx_word_src;
    end
  end

  logic [NCH-1:0][DSZ-1:0] rx_sh, rx_sh_nxt;
  logic                    primed;

  always_comb begin
    rx_sh_nxt = rx_sh;
    for (int unsigned i = 0; i < NCH; i++)
      if (32'(cur_slot) == i && 32'(cur_bit) < DSZ)
        rx_sh_nxt[i] = DSZ'({rx_sh[i], i2s_sdin});
  end

  always_ff @(posedge i2s_bclk or posedge reset) begin
    if (reset) begin
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      primed   <= 1'b0;
    end else begin
      rx_sh    <= rx_sh_nxt;
      rx_valid <= 1'b0;
      if (frame_start)
        primed <= 1'b1;
      if (frame_end && primed) begin
        rx_data  <= rx_sh_nxt;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule
